// File: rtl/axi_gpu_burst_mem.sv
// axi_gpu_burst_mem: AXI4 slave burst memory for a GPU node local-memory port.
// Independent read and write FSMs serve FIXED/INCR/WRAP bursts of up to 256
// beats with byte strobes, ID echo and SLVERR protocol checking.
// Optional feature macro: AXI_GPU_MEM_RANGE_CHECK_EN. When defined, beats whose
// address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) are answered with DECERR
// (writes dropped, reads return zero). When undefined, addresses alias modulo
// MEM_BYTES and DECERR is never produced.
module axi_gpu_burst_mem #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // write address
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWADDR,
  input  logic [7:0]          S_AWLEN,
  input  logic [2:0]          S_AWSIZE,
  input  logic [1:0]          S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  // write data
  input  logic [DATA_W-1:0]   S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  // write response
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  // read address
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARADDR,
  input  logic [7:0]          S_ARLEN,
  input  logic [2:0]          S_ARSIZE,
  input  logic [1:0]          S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  // read data
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  output logic                busy
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_AW = $clog2(STRB_W);
  localparam int DEPTH   = MEM_BYTES / STRB_W;
  localparam int IDX_W   = $clog2(DEPTH);

  localparam logic [2:0] MAX_SIZE = 3'(BYTE_AW);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Burst-level protocol violations that turn the response into SLVERR.
  function automatic logic proto_err(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
    proto_err = (size > MAX_SIZE) ||
                (burst == BURST_RSVD) ||
                ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // Address of the following beat. Reserved bursts and illegal WRAP lengths
  // fall back to INCR stepping so the burst still walks forward.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0]        size,
                                                  input logic [7:0]        len,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] stepped;
    logic [ADDR_W-1:0] wrap_mask;
    incr      = ADDR_W'(1) << size;
    stepped   = (addr & ~(incr - ADDR_W'(1))) + incr;
    wrap_mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
    next_addr = stepped;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      next_addr = (addr & ~wrap_mask) | (stepped & wrap_mask);
    end
  endfunction

  // Word index: offset from BASE_ADDR, modulo the memory size, in bus words.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> BYTE_AW);
  endfunction

`ifdef AXI_GPU_MEM_RANGE_CHECK_EN
  // Below-base addresses wrap to a huge offset, so one compare covers both ends.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    in_range = (addr - BASE_ADDR) < ADDR_W'(MEM_BYTES);
  endfunction
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_en_q, ready_en_d;

  logic [1:0]        w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [2:0]        w_size_q, w_size_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic              w_dec_q, w_dec_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;

  logic [0:0]        r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              r_err_q, r_err_d;
  logic              r_dec_q, r_dec_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] r_addr_step;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_oor;

  assign S_AWREADY = ready_en_q && (w_state_q == W_IDLE);
  assign S_WREADY  = (w_state_q == W_DATA);
  assign S_BVALID  = (w_state_q == W_RESP);
  assign S_BID     = w_id_q;
  assign S_BRESP   = w_dec_q ? RESP_DECERR : (w_err_q ? RESP_SLVERR : RESP_OKAY);

  assign S_ARREADY = ready_en_q && (r_state_q == R_IDLE);
  assign S_RVALID  = (r_state_q == R_DATA);
  assign S_RID     = r_id_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = r_dec_q ? RESP_DECERR : (r_err_q ? RESP_SLVERR : RESP_OKAY);
  assign S_RLAST   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  assign busy = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

  // The read port looks at the incoming AR address while idle and at the next
  // beat address while bursting, so the data is registered one beat ahead.
  assign r_addr_step = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
  assign rd_addr     = (r_state_q == R_IDLE) ? S_ARADDR : r_addr_step;
  assign rd_word     = mem[word_idx(rd_addr)];
  assign mem_widx    = word_idx(w_addr_q);

  // Out-of-range flag for the word about to be loaded into the read register.
  always_comb begin
    rd_oor = 1'b0;
`ifdef AXI_GPU_MEM_RANGE_CHECK_EN
    rd_oor = !in_range(rd_addr);
`endif
  end

  // Write FSM: accept AW, commit one strobed beat per W handshake, then hold B.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_dec_d   = w_dec_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (S_AWVALID && S_AWREADY) begin
          w_id_d    = S_AWID;
          w_addr_d  = S_AWADDR;
          w_len_d   = S_AWLEN;
          w_size_d  = S_AWSIZE;
          w_burst_d = S_AWBURST;
          w_cnt_d   = 8'd0;
          w_err_d   = proto_err(S_AWSIZE, S_AWLEN, S_AWBURST);
          w_dec_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_WVALID) begin
          mem_we   = 1'b1;
`ifdef AXI_GPU_MEM_RANGE_CHECK_EN
          if (!in_range(w_addr_q)) begin
            mem_we  = 1'b0;
            w_dec_d = 1'b1;
          end
`endif
          if (S_WLAST != (w_cnt_q == w_len_q)) begin
            w_err_d = 1'b1;
          end
          w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: accept AR, present beats back to back while RREADY, hold on stall.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_size_d   = r_size_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    r_err_d    = r_err_q;
    r_dec_d    = r_dec_q;
    rdata_d    = rdata_q;
    ready_en_d = 1'b1;
    case (r_state_q)
      R_IDLE: begin
        if (S_ARVALID && S_ARREADY) begin
          r_id_d    = S_ARID;
          r_addr_d  = S_ARADDR;
          r_len_d   = S_ARLEN;
          r_size_d  = S_ARSIZE;
          r_burst_d = S_ARBURST;
          r_cnt_d   = 8'd0;
          r_err_d   = proto_err(S_ARSIZE, S_ARLEN, S_ARBURST);
          r_dec_d   = rd_oor;
          rdata_d   = rd_oor ? '0 : rd_word;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_RREADY) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_addr_step;
            r_dec_d  = rd_oor;
            rdata_d  = rd_oor ? '0 : rd_word;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Control and response registers; reset drops any burst in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      w_dec_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      r_err_q    <= 1'b0;
      r_dec_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_size_q   <= w_size_d;
      w_burst_q  <= w_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      w_dec_q    <= w_dec_d;
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_size_q   <= r_size_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_err_q    <= r_err_d;
      r_dec_q    <= r_dec_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory array: byte-strobed writes, contents survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_WSTRB[b]) begin
          mem[mem_widx][b*8 +: 8] <= S_WDATA[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_gpu_burst_mem.sv
// Directed testbench for axi_gpu_burst_mem with hand-computed expectations.
module tb_axi_gpu_burst_mem;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int ID_W      = 4;
  localparam int MEM_BYTES = 8192;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   S_AWID;
  logic [ADDR_W-1:0] S_AWADDR;
  logic [7:0]        S_AWLEN;
  logic [2:0]        S_AWSIZE;
  logic [1:0]        S_AWBURST;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [DATA_W-1:0] S_WDATA;
  logic [7:0]        S_WSTRB;
  logic              S_WLAST;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [ID_W-1:0]   S_BID;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ID_W-1:0]   S_ARID;
  logic [ADDR_W-1:0] S_ARADDR;
  logic [7:0]        S_ARLEN;
  logic [2:0]        S_ARSIZE;
  logic [1:0]        S_ARBURST;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [ID_W-1:0]   S_RID;
  logic [DATA_W-1:0] S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RLAST;
  logic              S_RVALID;
  logic              S_RREADY;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] wrData [256];
  logic [7:0]  wrStrb [256];
  logic [63:0] rdData [256];
  logic [1:0]  rdResp [256];
  logic        rdLast [256];
  logic [1:0]  lastBresp;
  logic [3:0]  lastBid;
  logic [3:0]  lastRid;

  axi_gpu_burst_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .busy(busy)
  );

  // 100 MHz clock; the bench drives and samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a wedged handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Full write burst using wrData/wrStrb; WLAST is raised on beat lastBeat.
  task automatic axiWrite(input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int lastBeat);
    int waitCyc;
    S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = size;
    S_AWBURST = burst; S_AWVALID = 1'b1;
    waitCyc = 0;
    while (!S_AWREADY && waitCyc < 200) begin @(negedge clk); waitCyc++; end
    if (waitCyc >= 200) checkOutput("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    S_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_WDATA = wrData[i]; S_WSTRB = wrStrb[i];
      S_WLAST = (i == lastBeat); S_WVALID = 1'b1;
      waitCyc = 0;
      while (!S_WREADY && waitCyc < 200) begin @(negedge clk); waitCyc++; end
      if (waitCyc >= 200) checkOutput("w_timeout", 64'd0, 64'd1);
      @(negedge clk);
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    checkOutput("bvalid_latency", 64'(S_BVALID), 64'd1);
    S_BREADY = 1'b1;
    waitCyc = 0;
    while (!S_BVALID && waitCyc < 200) begin @(negedge clk); waitCyc++; end
    if (waitCyc >= 200) checkOutput("b_timeout", 64'd0, 64'd1);
    lastBresp = S_BRESP; lastBid = S_BID;
    @(negedge clk);
    S_BREADY = 1'b0;
    checkOutput("awready_after_b", 64'(S_AWREADY), 64'd1);
  endtask

  // Full read burst into rdData/rdResp/rdLast; stall toggles RREADY 0/1.
  task automatic axiRead(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic stall);
    int waitCyc;
    int beat;
    logic toggle;
    logic holdPending;
    logic [63:0] holdData;
    S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = size;
    S_ARBURST = burst; S_ARVALID = 1'b1;
    waitCyc = 0;
    while (!S_ARREADY && waitCyc < 200) begin @(negedge clk); waitCyc++; end
    if (waitCyc >= 200) checkOutput("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    S_ARVALID = 1'b0;
    checkOutput("rvalid_latency", 64'(S_RVALID), 64'd1);
    lastRid = S_RID;
    beat = 0; waitCyc = 0; toggle = 1'b0; holdPending = 1'b0; holdData = '0;
    while (beat <= int'(len) && waitCyc < 2000) begin
      if (holdPending) checkOutput("rdata_hold", S_RDATA, holdData);
      holdPending = 1'b0;
      S_RREADY = stall ? toggle : 1'b1;
      toggle = ~toggle;
      if (S_RVALID && S_RREADY) begin
        rdData[beat] = S_RDATA; rdResp[beat] = S_RRESP; rdLast[beat] = S_RLAST;
        beat++;
      end else if (S_RVALID) begin
        holdPending = 1'b1; holdData = S_RDATA;
      end
      @(negedge clk);
      waitCyc++;
    end
    S_RREADY = 1'b0;
    if (beat <= int'(len)) checkOutput("r_timeout", 64'd0, 64'd1);
    checkOutput("rvalid_done", 64'(S_RVALID), 64'd0);
  endtask

  // Directed scenario list: every expectation below is a hand-computed constant.
  task automatic applyStimulus();
    int waitCyc;
    // reset state
    rst = 1'b1;
    S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
    S_RREADY = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 64'(S_AWREADY), 64'd0);
    checkOutput("rst_arready", 64'(S_ARREADY), 64'd0);
    checkOutput("rst_bvalid", 64'(S_BVALID), 64'd0);
    checkOutput("rst_rvalid", 64'(S_RVALID), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rdata", S_RDATA, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("awready_before_edge", 64'(S_AWREADY), 64'd0);
    @(negedge clk);
    checkOutput("awready_after_rst", 64'(S_AWREADY), 64'd1);
    checkOutput("arready_after_rst", 64'(S_ARREADY), 64'd1);

    // INCR write then INCR read of four words at 0x1000
    wrData[0] = 64'h11; wrData[1] = 64'h22; wrData[2] = 64'h33; wrData[3] = 64'h44;
    for (int i = 0; i < 4; i++) wrStrb[i] = 8'hFF;
    axiWrite(32'h1000, 4'h5, 8'd3, 3'd3, 2'b01, 3);
    checkOutput("incr_bresp", 64'(lastBresp), 64'd0);
    checkOutput("incr_bid", 64'(lastBid), 64'h5);
    axiRead(32'h1000, 4'h9, 8'd3, 3'd3, 2'b01, 1'b0);
    checkOutput("incr_rid", 64'(lastRid), 64'h9);
    checkOutput("incr_d0", rdData[0], 64'h11);
    checkOutput("incr_d1", rdData[1], 64'h22);
    checkOutput("incr_d2", rdData[2], 64'h33);
    checkOutput("incr_d3", rdData[3], 64'h44);
    for (int i = 0; i < 4; i++) begin
      checkOutput("incr_rlast", 64'(rdLast[i]), (i == 3) ? 64'd1 : 64'd0);
      checkOutput("incr_rresp", 64'(rdResp[i]), 64'd0);
    end

    // WRAP read starting mid-window: 0x1010, 0x1018, 0x1000, 0x1008
    axiRead(32'h1010, 4'h2, 8'd3, 3'd3, 2'b10, 1'b0);
    checkOutput("wrap_d0", rdData[0], 64'h33);
    checkOutput("wrap_d1", rdData[1], 64'h44);
    checkOutput("wrap_d2", rdData[2], 64'h11);
    checkOutput("wrap_d3", rdData[3], 64'h22);
    checkOutput("wrap_resp", 64'(rdResp[3]), 64'd0);

    // FIXED read repeats the same word
    axiRead(32'h1008, 4'h1, 8'd1, 3'd3, 2'b00, 1'b0);
    checkOutput("fixed_d0", rdData[0], 64'h22);
    checkOutput("fixed_d1", rdData[1], 64'h22);

    // Partial strobe merges the low four bytes only
    wrData[0] = 64'hFACE_CAFE_DEAD_BEEF; wrStrb[0] = 8'hFF;
    axiWrite(32'h0200, 4'h3, 8'd0, 3'd3, 2'b01, 0);
    wrData[0] = 64'hFFFF_FFFF_FFFF_FFFF; wrStrb[0] = 8'h0F;
    axiWrite(32'h0200, 4'h3, 8'd0, 3'd3, 2'b01, 0);
    axiRead(32'h0200, 4'h3, 8'd0, 3'd3, 2'b01, 1'b0);
    checkOutput("strobe_merge", rdData[0], 64'hFACE_CAFE_FFFF_FFFF);

    // Stalled eight-beat read with a concurrent write elsewhere
    for (int i = 0; i < 8; i++) begin
      wrData[i] = 64'hC0DE_0000_0000_0000 | 64'(i); wrStrb[i] = 8'hFF;
    end
    axiWrite(32'h0400, 4'h4, 8'd7, 3'd3, 2'b01, 7);
    wrData[0] = 64'hAAAA_AAAA_AAAA_AAAA; wrData[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    fork
      axiRead(32'h0400, 4'h6, 8'd7, 3'd3, 2'b01, 1'b1);
      axiWrite(32'h0800, 4'h7, 8'd1, 3'd3, 2'b01, 1);
    join
    for (int i = 0; i < 8; i++) begin
      checkOutput("stall_data", rdData[i], 64'hC0DE_0000_0000_0000 | 64'(i));
    end
    checkOutput("stall_rlast", 64'(rdLast[7]), 64'd1);
    checkOutput("concurrent_bresp", 64'(lastBresp), 64'd0);
    axiRead(32'h0800, 4'h7, 8'd1, 3'd3, 2'b01, 1'b0);
    checkOutput("concurrent_d0", rdData[0], 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("concurrent_d1", rdData[1], 64'hBBBB_BBBB_BBBB_BBBB);

    // Early WLAST: still four beats, SLVERR, data committed
    for (int i = 0; i < 4; i++) begin
      wrData[i] = 64'h5000 + 64'(i); wrStrb[i] = 8'hFF;
    end
    axiWrite(32'h0C00, 4'h8, 8'd3, 3'd3, 2'b01, 1);
    checkOutput("wlast_early_bresp", 64'(lastBresp), 64'h2);
    axiRead(32'h0C18, 4'h8, 8'd0, 3'd3, 2'b01, 1'b0);
    checkOutput("wlast_early_commit", rdData[0], 64'h5003);

    // Oversized beat on a 64-bit bus
    wrData[0] = 64'h1234; wrStrb[0] = 8'hFF;
    axiWrite(32'h0E00, 4'hA, 8'd0, 3'd4, 2'b01, 0);
    checkOutput("size_bresp", 64'(lastBresp), 64'h2);

    // Reserved burst type reads as INCR with SLVERR
    axiRead(32'h1000, 4'hB, 8'd1, 3'd3, 2'b11, 1'b0);
    checkOutput("rsvd_resp", 64'(rdResp[0]), 64'h2);
    checkOutput("rsvd_d1", rdData[1], 64'h22);

    // WRAP with three beats is illegal: SLVERR, INCR stepping
    axiRead(32'h1000, 4'hC, 8'd2, 3'd3, 2'b10, 1'b0);
    checkOutput("wraplen_resp", 64'(rdResp[2]), 64'h2);
    checkOutput("wraplen_d2", rdData[2], 64'h33);

`ifdef AXI_GPU_MEM_RANGE_CHECK_EN
    // Out-of-range read gets DECERR and zero data
    axiRead(BASE_ADDR + 32'h2000, 4'hD, 8'd0, 3'd3, 2'b01, 1'b0);
    checkOutput("decerr_resp", 64'(rdResp[0]), 64'h3);
    checkOutput("decerr_data", rdData[0], 64'd0);
`else
    // Without range checking the address aliases onto 0x1000
    axiRead(32'h3000, 4'hD, 8'd0, 3'd3, 2'b01, 1'b0);
    checkOutput("alias_resp", 64'(rdResp[0]), 64'd0);
    checkOutput("alias_data", rdData[0], 64'h11);
`endif

    // Reset in the middle of a read burst
    S_ARID = 4'hE; S_ARADDR = 32'h1000; S_ARLEN = 8'd7; S_ARSIZE = 3'd3;
    S_ARBURST = 2'b01; S_ARVALID = 1'b1;
    waitCyc = 0;
    while (!S_ARREADY && waitCyc < 200) begin @(negedge clk); waitCyc++; end
    if (waitCyc >= 200) checkOutput("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    S_ARVALID = 1'b0; S_RREADY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrd_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrd_rvalid", 64'(S_RVALID), 64'd0);
    checkOutput("midrd_busy_rst", 64'(busy), 64'd0);
    S_RREADY = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrd_arready", 64'(S_ARREADY), 64'd1);
    axiRead(32'h1018, 4'hF, 8'd0, 3'd3, 2'b01, 1'b0);
    checkOutput("mem_kept", rdData[0], 64'h44);
  endtask

  // Run the scenario list and print the summary.
  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
